// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and widths for the 8-bit core pipeline hazard controller.
//   ctrl_state_t : controller FSM states
//   REG_W        : register index width
//   DATA_W       : datapath width of the core
//   FLUSH_W      : width of the wrong-path flush counter
//   WAIT_W       : width of the memory wait counter
//   STALL_W      : width of the saturating stall counter
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        S_INIT     = 2'd0,
        S_RUN      = 2'd1,
        S_FLUSH    = 2'd2,
        S_MEM_WAIT = 2'd3
    } ctrl_state_t;

    localparam int REG_W   = 3;
    localparam int DATA_W  = 8;
    localparam int FLUSH_W = 2;
    localparam int WAIT_W  = 8;
    localparam int STALL_W = 16;

endpackage

// File: rtl/hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Combinational load-use hazard detection between the ID and EX stages.
// Ports:
//   id_rs, id_rt         in  source register fields of the ID instruction
//   id_use_rs, id_use_rt in  ID instruction actually reads rs / rt
//   ex_rd                in  destination register of the EX instruction
//   ex_mem_to_reg        in  EX instruction is a load
//   ex_reg_wr            in  EX instruction writes a register
//   lu                   out load-use hazard present this cycle
// -----------------------------------------------------------------------------
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int R0_IS_ZERO = 1
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_to_reg,
    input  logic             ex_reg_wr,
    output logic             lu
);

    logic rd_valid;
    logic rs_hit;
    logic rt_hit;

    always_comb begin
        // With r0 hardwired a load into r0 is discarded, so it cannot feed ID.
        rd_valid = (ex_rd != '0) || (R0_IS_ZERO == 0);
        rs_hit   = id_use_rs && (id_rs == ex_rd);
        rt_hit   = id_use_rt && (id_rt == ex_rd);
        lu       = ex_mem_to_reg && ex_reg_wr && rd_valid && (rs_hit || rt_hit);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Sequences the IF/ID, ID/EX and EX/MEM pipeline registers of the 8-bit core:
// load-use stalls, wrong-path flushes after taken jumps resolved in EX, and a
// whole-pipe freeze while a data-memory access is outstanding.
// Ports:
//   clk, rst                  rising-edge clock, async active-high reset
//   id_rs, id_rt              ID source register fields
//   id_use_rs, id_use_rt      ID instruction reads rs / rt
//   ex_rd                     EX destination register
//   ex_memToReg, ex_regWr     EX instruction is a load / writes a register
//   ex_jtaken                 jump resolved taken in EX
//   mem_req, mem_ready        MEM access pending / completing this cycle
//   pc_en                     pc load enable
//   ifid_en, ifid_flush       IF/ID load enable / load NOP
//   idex_en, idex_bubble      ID/EX load enable / load zero control
//   exmem_en                  EX/MEM load enable
//   stall_cnt                 saturating count of cycles with pc_en==0
//   timeout_err               sticky memory wait timeout flag
// Control outputs are combinational so a stall acts in the cycle it is seen.
// Handshake: mem_req with mem_ready low means the access is not done; the
// pipe stays frozen until a cycle where mem_ready is high.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int WAIT_TIMEOUT = 255,
    parameter int R0_IS_ZERO   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [REG_W-1:0]   id_rs,
    input  logic [REG_W-1:0]   id_rt,
    input  logic               id_use_rs,
    input  logic               id_use_rt,
    input  logic [REG_W-1:0]   ex_rd,
    input  logic               ex_memToReg,
    input  logic               ex_regWr,
    input  logic               ex_jtaken,
    input  logic               mem_req,
    input  logic               mem_ready,
    output logic               pc_en,
    output logic               ifid_en,
    output logic               ifid_flush,
    output logic               idex_en,
    output logic               idex_bubble,
    output logic               exmem_en,
    output logic [STALL_W-1:0] stall_cnt,
    output logic               timeout_err
);

    localparam logic [FLUSH_W-1:0] FLUSH_RELOAD = FLUSH_W'(FLUSH_CYCLES - 1);
    localparam logic [WAIT_W-1:0]  TIMEOUT_CNT  = WAIT_W'(WAIT_TIMEOUT);

    ctrl_state_t        state_q, state_d;
    logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic               timeout_err_q, timeout_err_d;

    logic lu;
    logic mem_stall;

    hazard_detect #(
        .R0_IS_ZERO (R0_IS_ZERO)
    ) u_hazard_detect (
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_use_rs     (id_use_rs),
        .id_use_rt     (id_use_rt),
        .ex_rd         (ex_rd),
        .ex_mem_to_reg (ex_memToReg),
        .ex_reg_wr     (ex_regWr),
        .lu            (lu)
    );

    assign mem_stall = mem_req && !mem_ready;

    // Next state and control outputs.
    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
        pc_en         = 1'b1;
        ifid_en       = 1'b1;
        ifid_flush    = 1'b0;
        idex_en       = 1'b1;
        idex_bubble   = 1'b0;
        exmem_en      = 1'b1;

        case (state_q)
            S_INIT: begin
                // Fill the pipe with NOPs for one cycle.
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                state_d     = S_RUN;
            end

            S_RUN: begin
                if (mem_stall) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_en    = 1'b0;
                    exmem_en   = 1'b0;
                    wait_cnt_d = WAIT_W'(1);
                    state_d    = S_MEM_WAIT;
                end else if (ex_jtaken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        flush_cnt_d = FLUSH_RELOAD;
                        state_d     = S_FLUSH;
                    end
                end else if (lu) begin
                    // Hold IF and ID, insert one bubble into EX.
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                end
            end

            S_FLUSH: begin
                if (mem_stall) begin
                    // Freeze; the flush counter is held and flushing resumes later.
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_en    = 1'b0;
                    exmem_en   = 1'b0;
                    wait_cnt_d = WAIT_W'(1);
                    state_d    = S_MEM_WAIT;
                end else begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    if (flush_cnt_q <= FLUSH_W'(1)) begin
                        flush_cnt_d = '0;
                        state_d     = S_RUN;
                    end else begin
                        flush_cnt_d = flush_cnt_q - FLUSH_W'(1);
                    end
                end
            end

            S_MEM_WAIT: begin
                if (mem_ready) begin
                    wait_cnt_d = '0;
                    state_d    = (flush_cnt_q != '0) ? S_FLUSH : S_RUN;
                end else begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exmem_en = 1'b0;
                    if (wait_cnt_q != '1) begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                    if (wait_cnt_q == TIMEOUT_CNT) begin
                        timeout_err_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_INIT;
            end
        endcase

        // Reset overrides everything combinationally so the pipe holds at once.
        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_en     = 1'b0;
            idex_bubble = 1'b1;
            exmem_en    = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_en && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_INIT;
            flush_cnt_q   <= '0;
            wait_cnt_q    <= '0;
            stall_cnt_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign stall_cnt   = stall_cnt_q;
    assign timeout_err = timeout_err_q;

endmodule
